cv_btn_fltr_n: RTL and testbench

Parametrised multi-channel successor to the single-button filter in the sequence generator front end. Each of `N` asynchronous button inputs is synchronised, debounced over a programmable number of clock-enable ticks and turned into a stable level plus single-cycle press and release strobes. It adds long-press detection and optional auto-repeat, so mode and step buttons can be held down to scroll. It sits between the board pins and the control FSM, and runs in the system clock domain.

---
 rtl/cv_btn_pkg.sv | 36 +++
 rtl/cv_btn_fltr_ch.sv | 147 ++++++++++++++
 rtl/cv_btn_fltr_n.sv | 42 ++++
 tb/tb_cv_btn_fltr_n.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cv_btn_pkg.sv
// rtl/cv_btn_pkg.sv - shared state encoding, default parameters and width helpers for the button filter
package cv_btn_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_DEBOUNCE   = 16;
  localparam int DEF_LONG_CNT   = 1000;
  localparam int DEF_RPT_CNT    = 200;
  localparam int DEF_ACTIVE_LOW = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } btn_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/cv_btn_fltr_ch.sv
// rtl/cv_btn_fltr_ch.sv - one button channel: synchroniser, debounce, press/long/repeat state machine
module cv_btn_fltr_ch
  import cv_btn_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int LONG_CNT = DEF_LONG_CNT,
  parameter int RPT_CNT  = DEF_RPT_CNT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic long_o
);

  localparam int DW = cnt_width(DEBOUNCE);
  localparam int HW = cnt_width(max2(LONG_CNT, RPT_CNT));

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] RPT_LAST  = (RPT_CNT > 0) ? HW'(RPT_CNT - 1) : '0;
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  btn_state_e    state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          qual;

  // Two-flop synchroniser; keeps sampling regardless of CE, loads released level on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
    end
  end

  // Debounce: any cycle of agreement clears the count; DEBOUNCE consecutive disagreeing ticks flip the level.
  always_comb begin
    deb_d    = deb_q;
    stable_d = stable_q;
    qual     = 1'b0;
    if (s2_q == stable_q) begin
      deb_d = '0;
    end else if (ce_i) begin
      if (deb_q == DEB_LAST) begin
        deb_d    = '0;
        stable_d = ~stable_q;
        qual     = 1'b1;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  // Press/long/repeat next-state and strobe decode; a qualified release takes priority over hold expiry.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (qual && !stable_q) begin
          state_d = PRESS;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      PRESS: begin
        if (qual && stable_q) begin
          state_d = IDLE;
          hold_d  = '0;
          rel_d   = 1'b1;
        end else if (ce_i) begin
          if (hold_q == LONG_LAST) begin
            state_d = LONG;
            hold_d  = '0;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      LONG: begin
        if (qual && stable_q) begin
          state_d = IDLE;
          hold_d  = '0;
          rel_d   = 1'b1;
        end else if (ce_i) begin
          if (RPT_CNT > 0) begin
            if (hold_q == RPT_LAST) begin
              hold_d  = '0;
              press_d = 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Filter state, counters and registered strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= 1'b0;
      deb_q    <= '0;
      hold_q   <= '0;
      state_q  <= IDLE;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign long_o  = long_q;

endmodule

// File: rtl/cv_btn_fltr_n.sv
// rtl/cv_btn_fltr_n.sv - N-channel button filter with debounce, long-press and auto-repeat
module cv_btn_fltr_n
  import cv_btn_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DEBOUNCE   = DEF_DEBOUNCE,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int RPT_CNT    = DEF_RPT_CNT,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic [N-1:0] BTN_IN,
  output logic [N-1:0] BTN_OUT,
  output logic [N-1:0] BTN_CEO,
  output logic [N-1:0] BTN_REL,
  output logic [N-1:0] BTN_LONG
);

  logic [N-1:0] pin_pressed;

  assign pin_pressed = (ACTIVE_LOW != 0) ? ~BTN_IN : BTN_IN;

  for (genvar g = 0; g < N; g++) begin : g_ch
    cv_btn_fltr_ch #(
      .DEBOUNCE (DEBOUNCE),
      .LONG_CNT (LONG_CNT),
      .RPT_CNT  (RPT_CNT)
    ) u_ch (
      .clk_i   (CLK),
      .rst_i   (RST),
      .ce_i    (CE),
      .pin_i   (pin_pressed[g]),
      .level_o (BTN_OUT[g]),
      .press_o (BTN_CEO[g]),
      .rel_o   (BTN_REL[g]),
      .long_o  (BTN_LONG[g])
    );
  end

endmodule

// File: tb/tb_cv_btn_fltr_n.sv
// tb/tb_cv_btn_fltr_n.sv - directed self-checking bench for cv_btn_fltr_n
module tb_cv_btn_fltr_n;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [3:0] btn, btn_al;
  logic [3:0] out, ceo, rel, lng;
  logic [3:0] out_al, ceo_al, rel_al, lng_al;

  int checks;
  int failures;
  int ceo_cnt [4];
  int rel_cnt [4];
  int long_cnt[4];
  int out_cyc [4];

  logic [3:0] eo, ec, el, er;
  logic       bval;
  int         blen, bcyc;

  cv_btn_fltr_n #(
    .N(4), .DEBOUNCE(8), .LONG_CNT(32), .RPT_CNT(16), .ACTIVE_LOW(0)
  ) dut (
    .CLK(clk), .RST(rst), .CE(ce), .BTN_IN(btn),
    .BTN_OUT(out), .BTN_CEO(ceo), .BTN_REL(rel), .BTN_LONG(lng)
  );

  cv_btn_fltr_n #(
    .N(4), .DEBOUNCE(8), .LONG_CNT(32), .RPT_CNT(16), .ACTIVE_LOW(1)
  ) dut_al (
    .CLK(clk), .RST(rst), .CE(ce), .BTN_IN(btn_al),
    .BTN_OUT(out_al), .BTN_CEO(ceo_al), .BTN_REL(rel_al), .BTN_LONG(lng_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [3:0] o, input logic [3:0] c,
                                        input logic [3:0] l, input logic [3:0] r);
    return {16'h0, o, c, l, r};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int c = 0; c < 4; c++) begin
      ceo_cnt[c]  = 0;
      rel_cnt[c]  = 0;
      long_cnt[c] = 0;
      out_cyc[c]  = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        ceo_cnt[c]  += int'(ceo[c]);
        rel_cnt[c]  += int'(rel[c]);
        long_cnt[c] += int'(lng[c]);
        out_cyc[c]  += int'(out[c]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ce       = 1'b1;
    btn      = 4'h0;
    btn_al   = 4'hF;
    clr_counts();

    // reset state
    repeat (3) tick();
    check("rst_outputs", pack4(out, ceo, lng, rel), 32'h0);
    check("rst_outputs_al", pack4(out_al, ceo_al, lng_al, rel_al), 32'h0);
    rst = 1'b0;
    run(4);
    check("post_rst_idle", pack4(out, ceo, lng, rel), 32'h0);

    // bounce then press on ch0: runs of at most 5 cycles never qualify
    clr_counts();
    bval = 1'b0;
    bcyc = 0;
    while (bcyc < 50) begin
      blen   = $urandom_range(5, 1);
      bval   = ~bval;
      btn[0] = bval;
      run(blen);
      bcyc += blen;
    end
    if (bval) begin
      btn[0] = 1'b0;
      run(2);
    end
    check("bounce_no_ceo", ceo_cnt[0], 0);
    check("bounce_no_out", out_cyc[0], 0);
    btn[0] = 1'b1;
    run(9);
    check("bounce_edge9_low", 32'(out), 32'h0);
    tick();
    check("bounce_edge10", pack4(out, ceo, lng, rel), pack4(4'h1, 4'h1, 4'h0, 4'h0));
    tick();
    check("bounce_edge11", pack4(out, ceo, lng, rel), pack4(4'h1, 4'h0, 4'h0, 4'h0));
    btn[0] = 1'b0;
    run(9);
    check("bounce_rel_edge9", pack4(out, ceo, lng, rel), pack4(4'h1, 4'h0, 4'h0, 4'h0));
    tick();
    check("bounce_rel_edge10", pack4(out, ceo, lng, rel), pack4(4'h0, 4'h0, 4'h0, 4'h1));
    run(5);

    // glitch rejection on ch1
    clr_counts();
    btn[1] = 1'b1;
    run(7);
    btn[1] = 1'b0;
    run(15);
    check("glitch7_out", out_cyc[0] + out_cyc[1] + out_cyc[2] + out_cyc[3], 0);
    check("glitch7_ceo", ceo_cnt[0] + ceo_cnt[1] + ceo_cnt[2] + ceo_cnt[3], 0);
    check("glitch7_rel", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);
    clr_counts();
    btn[1] = 1'b1;
    run(8);
    btn[1] = 1'b0;
    run(20);
    check("pulse8_ceo", ceo_cnt[1], 1);
    check("pulse8_rel", rel_cnt[1], 1);
    check("pulse8_out_cycles", out_cyc[1], 8);
    check("pulse8_other_ch", ceo_cnt[0] + ceo_cnt[2] + ceo_cnt[3] + rel_cnt[0] + rel_cnt[2] + rel_cnt[3], 0);

    // long press and repeat on ch2, cycle by cycle
    btn[2] = 1'b1;
    for (int t = 1; t <= 115; t++) begin
      tick();
      eo = (t >= 10 && t < 102) ? 4'h4 : 4'h0;
      ec = (t == 10 || t == 58 || t == 74 || t == 90) ? 4'h4 : 4'h0;
      el = (t == 42) ? 4'h4 : 4'h0;
      er = (t == 102) ? 4'h4 : 4'h0;
      check($sformatf("long_rpt_t%0d", t), pack4(out, ceo, lng, rel), pack4(eo, ec, el, er));
      if (t == 92) btn[2] = 1'b0;
    end

    // release qualifying on the same tick the hold counter expires
    btn[2] = 1'b1;
    for (int t = 1; t <= 55; t++) begin
      tick();
      eo = (t >= 10 && t < 42) ? 4'h4 : 4'h0;
      ec = (t == 10) ? 4'h4 : 4'h0;
      el = 4'h0;
      er = (t == 42) ? 4'h4 : 4'h0;
      check($sformatf("rel_prio_t%0d", t), pack4(out, ceo, lng, rel), pack4(eo, ec, el, er));
      if (t == 32) btn[2] = 1'b0;
    end

    // CE one cycle in four, press and hold on ch3
    btn[3] = 1'b1;
    for (int t = 1; t <= 210; t++) begin
      ce = (t % 4 == 0);
      tick();
      eo = (t >= 32 && t < 204) ? 4'h8 : 4'h0;
      ec = (t == 32) ? 4'h8 : 4'h0;
      el = (t == 160) ? 4'h8 : 4'h0;
      er = (t == 204) ? 4'h8 : 4'h0;
      check($sformatf("ce_gate_t%0d", t), pack4(out, ceo, lng, rel), pack4(eo, ec, el, er));
      if (t == 170) btn[3] = 1'b0;
    end
    ce = 1'b1;
    run(5);

    // reset during a held press on ch0
    btn[0] = 1'b1;
    run(9);
    check("rstp_pre_low", 32'(out), 32'h0);
    tick();
    check("rstp_press", pack4(out, ceo, lng, rel), pack4(4'h1, 4'h1, 4'h0, 4'h0));
    run(5);
    rst = 1'b1;
    tick();
    check("rstp_cleared", pack4(out, ceo, lng, rel), 32'h0);
    rst = 1'b0;
    clr_counts();
    run(9);
    check("rstp_requal_low", 32'(out), 32'h0);
    tick();
    check("rstp_requal_ceo", pack4(out, ceo, lng, rel), pack4(4'h1, 4'h1, 4'h0, 4'h0));
    check("rstp_no_rel", rel_cnt[0], 0);
    clr_counts();
    btn[0] = 1'b0;
    run(10);
    check("rstp_final_rel", rel_cnt[0], 1);
    check("rstp_final_out", 32'(out), 32'h0);

    // active-low instance, all four pins pressed together
    btn_al = 4'h0;
    repeat (9) tick();
    check("al_edge9", pack4(out_al, ceo_al, lng_al, rel_al), 32'h0);
    tick();
    check("al_press_all", pack4(out_al, ceo_al, lng_al, rel_al), pack4(4'hF, 4'hF, 4'h0, 4'h0));
    tick();
    check("al_ceo_one_wide", pack4(out_al, ceo_al, lng_al, rel_al), pack4(4'hF, 4'h0, 4'h0, 4'h0));
    btn_al = 4'hF;
    repeat (10) tick();
    check("al_rel_all", pack4(out_al, ceo_al, lng_al, rel_al), pack4(4'h0, 4'h0, 4'h0, 4'hF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
